// File: rtl/sram_arbiter_pkg.sv
// Shared widths, encodings and defaults for the SRAM arbiter slice.
package sram_arbiter_pkg;

    // ISA widths the arbiter bus is sized against.
    localparam int LEN_ADDRESS  = 32;
    localparam int LEN_REGISTER = 32;

    // SRAM access time in clock cycles.
    localparam int SRAM_WAIT_CYCLES = 4;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_t;

    // Which stage owns the access currently in flight.
    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

    // Wait counter width: enough to hold WAIT_CYCLES-1, never below one bit.
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Stage-side and SRAM-side signals of the arbiter, bundled as one bus.
interface sram_arbiter_if #(
    parameter int ADDR_W = sram_arbiter_pkg::LEN_ADDRESS,
    parameter int DATA_W = sram_arbiter_pkg::LEN_REGISTER
);
    // IF stage
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    // MEM stage
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              freeze;
    // SRAM pins
    logic              sram_en;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    // The arbiter itself.
    modport slave (
        input  if_req, if_addr, mem_read, mem_write, mem_addr, mem_wdata, sram_rdata,
        output if_rdata, if_ready, mem_rdata, mem_ready, freeze,
        output sram_en, sram_we, sram_addr, sram_wdata
    );

    // The surroundings: pipeline stages and the SRAM.
    modport master (
        output if_req, if_addr, mem_read, mem_write, mem_addr, mem_wdata, sram_rdata,
        input  if_rdata, if_ready, mem_rdata, mem_ready, freeze,
        input  sram_en, sram_we, sram_addr, sram_wdata
    );

endinterface

// File: rtl/sram_wait_counter.sv
// Loadable down-counter that times one SRAM access; zero marks the last wait cycle.
module sram_wait_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);
    logic [WIDTH-1:0] count;

    // Load takes priority; otherwise count down and hold at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sram_arbiter.sv
// Shares one SRAM port between IF and MEM with fixed MEM priority, a fixed
// access latency, one-cycle ready pulses and a combinational pipeline freeze.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int ADDR_W      = LEN_ADDRESS,
    parameter int DATA_W      = LEN_REGISTER,
    parameter int WAIT_CYCLES = SRAM_WAIT_CYCLES
) (
    input  logic          clk,
    input  logic          rst,
    sram_arbiter_if.slave bus
);
    localparam int               CNT_W    = cnt_width(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    arb_state_t        state;
    owner_t            owner;
    logic              sram_en_q;
    logic              sram_we_q;
    logic [ADDR_W-1:0] sram_addr_q;
    logic [DATA_W-1:0] sram_wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] mem_rdata_q;
    logic              if_ready_q;
    logic              mem_ready_q;

    logic mem_req;
    logic grant;
    logic cnt_zero;

    // Either MEM strobe counts as a request; both high is handled as a write.
    assign mem_req = bus.mem_read | bus.mem_write;
    assign grant   = (state == ARB_IDLE) && (mem_req || bus.if_req);

    // Access timer: loaded on grant, counts down while the access is in flight.
    sram_wait_counter #(
        .WIDTH (CNT_W)
    ) u_wait_counter (
        .clk        (clk),
        .rst_n      (rst),
        .load       (grant),
        .load_value (CNT_LOAD),
        .dec        (state == ARB_BUSY),
        .zero       (cnt_zero)
    );

    // Arbitration FSM with registered SRAM strobes, read data and ready pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ARB_IDLE;
            owner        <= OWN_IF;
            sram_en_q    <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            if_rdata_q   <= '0;
            mem_rdata_q  <= '0;
            if_ready_q   <= 1'b0;
            mem_ready_q  <= 1'b0;
        end else begin
            // Ready outputs are single-cycle pulses unless set below.
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;

            case (state)
                ARB_IDLE: begin
                    if (mem_req) begin
                        owner        <= OWN_MEM;
                        sram_addr_q  <= bus.mem_addr;
                        sram_wdata_q <= bus.mem_wdata;
                        sram_we_q    <= bus.mem_write;
                        sram_en_q    <= 1'b1;
                        state        <= ARB_BUSY;
                    end else if (bus.if_req) begin
                        owner       <= OWN_IF;
                        sram_addr_q <= bus.if_addr;
                        sram_we_q   <= 1'b0;
                        sram_en_q   <= 1'b1;
                        state       <= ARB_BUSY;
                    end
                end

                ARB_BUSY: begin
                    if (cnt_zero) begin
                        sram_en_q <= 1'b0;
                        sram_we_q <= 1'b0;
                        state     <= ARB_DONE;
                        // A requester that withdrew mid-access gets neither data nor ready.
                        if (owner == OWN_MEM) begin
                            if (mem_req) begin
                                mem_ready_q <= 1'b1;
                                if (!sram_we_q) begin
                                    mem_rdata_q <= bus.sram_rdata;
                                end
                            end
                        end else if (bus.if_req) begin
                            if_ready_q <= 1'b1;
                            if_rdata_q <= bus.sram_rdata;
                        end
                    end
                end

                // Ready is high here; never re-grant so a held request is not reissued.
                ARB_DONE: state <= ARB_IDLE;

                default: state <= ARB_IDLE;
            endcase
        end
    end

    assign bus.sram_en    = sram_en_q;
    assign bus.sram_we    = sram_we_q;
    assign bus.sram_addr  = sram_addr_q;
    assign bus.sram_wdata = sram_wdata_q;
    assign bus.if_rdata   = if_rdata_q;
    assign bus.if_ready   = if_ready_q;
    assign bus.mem_rdata  = mem_rdata_q;
    assign bus.mem_ready  = mem_ready_q;

    // Stall the pipeline while a MEM access is pending; released in its ready cycle.
    assign bus.freeze = mem_req & ~mem_ready_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: scenario tasks with a per-port
// scoreboard of expected ready cycles and read data.
module tb_sram_arbiter;

    typedef struct {
        logic [31:0] data;
        int          cycle;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    exp_t if_q[$];
    exp_t mem_q[$];

    // Activity seen by the monitor
    int   if_pulses = 0;
    int   mem_pulses = 0;
    int   en_rises = 0;
    logic prev_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();

    sram_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .WAIT_CYCLES (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // SRAM content model: one fixed instruction word, otherwise an address pattern.
    function automatic logic [31:0] rd_pattern(input logic [31:0] a);
        return (a == 32'h40) ? 32'hE3A00005 : {a[15:0], ~a[15:0]};
    endfunction

    assign bus.sram_rdata = rd_pattern(bus.sram_addr);

    always @(negedge clk) begin
        if (bus.if_ready === 1'b1) if_pulses++;
        if (bus.mem_ready === 1'b1) mem_pulses++;
        if (bus.sram_en === 1'b1 && prev_en !== 1'b1) en_rises++;
        prev_en = bus.sram_en;
    end

    task automatic test_reset();
        bus.if_req = 0; bus.if_addr = 0; bus.mem_read = 0; bus.mem_write = 0;
        bus.mem_addr = 0; bus.mem_wdata = 0;
        rst = 0;
        repeat (2) @(negedge clk);
        total++;
        if ({bus.sram_en, bus.sram_we, bus.if_ready, bus.mem_ready} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_strobes got=%b want=0000",
                     {bus.sram_en, bus.sram_we, bus.if_ready, bus.mem_ready});
        end
        total++;
        if (bus.sram_addr !== 32'h0 || bus.sram_wdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_sram_bus got=%h/%h want=0/0", bus.sram_addr, bus.sram_wdata);
        end
        total++;
        if (bus.if_rdata !== 32'h0 || bus.mem_rdata !== 32'h0 || bus.freeze !== 1'b0) begin
            bad++;
            $display("FAIL reset_rdata got=%h/%h frz=%b want=0/0 frz=0",
                     bus.if_rdata, bus.mem_rdata, bus.freeze);
        end
        rst = 1;
    endtask

    task automatic test_if_read();
        exp_t e;
        int   t0;
        bit   en_ok = 1, fr_ok = 1;
        @(posedge clk); #1;
        bus.if_req = 1; bus.if_addr = 32'h40;
        t0 = cyc;
        if_q.push_back('{32'hE3A00005, t0 + 5});
        for (int rel = 0; rel <= 6; rel++) begin
            @(negedge clk);
            if (bus.sram_en !== (rel >= 1 && rel <= 4)) en_ok = 0;
            if (bus.freeze !== 1'b0) fr_ok = 0;
            if (bus.if_ready === 1'b1) begin
                total++;
                if (if_q.size() == 0) begin
                    bad++; $display("FAIL if_read_extra got=ready@%0d want=none", rel);
                end else begin
                    e = if_q.pop_front();
                    if (bus.if_rdata !== e.data || cyc != e.cycle) begin
                        bad++;
                        $display("FAIL if_read_data got=%h@%0d want=%h@%0d", bus.if_rdata, cyc, e.data, e.cycle);
                    end
                end
            end
            if (rel == 5) bus.if_req = 0;
        end
        total++;
        if (!en_ok) begin bad++; $display("FAIL if_read_en got=bad_window want=cycles1-4"); end
        total++;
        if (!fr_ok) begin bad++; $display("FAIL if_read_freeze got=1 want=0"); end
        total++;
        if (if_q.size() != 0) begin
            bad++; $display("FAIL if_read_missing got=no_ready want=ready@%0d", t0 + 5); if_q.delete();
        end
    endtask

    task automatic test_priority();
        exp_t e;
        int   t0;
        bit   en_ok = 1, fr_ok = 1, addr_ok = 1;
        @(posedge clk); #1;
        bus.if_req = 1; bus.if_addr = 32'h80;
        bus.mem_read = 1; bus.mem_addr = 32'h200;
        t0 = cyc;
        mem_q.push_back('{rd_pattern(32'h200), t0 + 5});
        if_q.push_back('{rd_pattern(32'h80), t0 + 11});
        for (int rel = 0; rel <= 12; rel++) begin
            @(negedge clk);
            if (bus.sram_en !== ((rel >= 1 && rel <= 4) || (rel >= 7 && rel <= 10))) en_ok = 0;
            if (bus.freeze !== (rel <= 4)) fr_ok = 0;
            if (rel >= 1 && rel <= 4 && bus.sram_addr !== 32'h200) addr_ok = 0;
            if (rel >= 7 && rel <= 10 && bus.sram_addr !== 32'h80) addr_ok = 0;
            if (bus.mem_ready === 1'b1) begin
                total++;
                if (mem_q.size() == 0) begin
                    bad++; $display("FAIL prio_mem_extra got=ready@%0d want=none", rel);
                end else begin
                    e = mem_q.pop_front();
                    if (bus.mem_rdata !== e.data || cyc != e.cycle) begin
                        bad++;
                        $display("FAIL prio_mem_data got=%h@%0d want=%h@%0d", bus.mem_rdata, cyc, e.data, e.cycle);
                    end
                end
            end
            if (bus.if_ready === 1'b1) begin
                total++;
                if (if_q.size() == 0) begin
                    bad++; $display("FAIL prio_if_extra got=ready@%0d want=none", rel);
                end else begin
                    e = if_q.pop_front();
                    if (bus.if_rdata !== e.data || cyc != e.cycle) begin
                        bad++;
                        $display("FAIL prio_if_data got=%h@%0d want=%h@%0d", bus.if_rdata, cyc, e.data, e.cycle);
                    end
                end
            end
            if (rel == 5) bus.mem_read = 0;
            if (rel == 11) bus.if_req = 0;
        end
        total++;
        if (!en_ok) begin bad++; $display("FAIL prio_en got=bad_window want=cycles1-4,7-10"); end
        total++;
        if (!fr_ok) begin bad++; $display("FAIL prio_freeze got=bad_window want=cycles0-4"); end
        total++;
        if (!addr_ok) begin bad++; $display("FAIL prio_addr got=wrong_owner_addr want=200_then_80"); end
        total++;
        if (mem_q.size() != 0 || if_q.size() != 0) begin
            bad++;
            $display("FAIL prio_missing got=pending mem=%0d if=%0d want=0", mem_q.size(), if_q.size());
            mem_q.delete(); if_q.delete();
        end
    endtask

    task automatic test_mem_write();
        exp_t e;
        int   t0;
        bit   we_ok = 1, fr_ok = 1;
        @(posedge clk); #1;
        bus.mem_write = 1; bus.mem_addr = 32'h100; bus.mem_wdata = 32'hDEADBEEF;
        t0 = cyc;
        // Load data from the previous MEM read must survive the write.
        mem_q.push_back('{rd_pattern(32'h200), t0 + 5});
        for (int rel = 0; rel <= 6; rel++) begin
            @(negedge clk);
            if (rel >= 1 && rel <= 4) begin
                if (bus.sram_en !== 1'b1 || bus.sram_we !== 1'b1 ||
                    bus.sram_addr !== 32'h100 || bus.sram_wdata !== 32'hDEADBEEF) we_ok = 0;
            end else if (bus.sram_we !== 1'b0) begin
                we_ok = 0;
            end
            if (bus.freeze !== (rel <= 4)) fr_ok = 0;
            if (bus.mem_ready === 1'b1) begin
                total++;
                if (mem_q.size() == 0) begin
                    bad++; $display("FAIL wr_extra got=ready@%0d want=none", rel);
                end else begin
                    e = mem_q.pop_front();
                    if (bus.mem_rdata !== e.data || cyc != e.cycle) begin
                        bad++;
                        $display("FAIL wr_ready got=%h@%0d want=%h@%0d", bus.mem_rdata, cyc, e.data, e.cycle);
                    end
                end
            end
            if (rel == 5) bus.mem_write = 0;
        end
        total++;
        if (!we_ok) begin bad++; $display("FAIL wr_pins got=unstable want=we/100/DEADBEEF cycles1-4"); end
        total++;
        if (!fr_ok) begin bad++; $display("FAIL wr_freeze got=bad_window want=cycles0-4"); end
        total++;
        if (mem_q.size() != 0) begin
            bad++; $display("FAIL wr_missing got=no_ready want=ready@%0d", t0 + 5); mem_q.delete();
        end
    endtask

    task automatic test_if_flush();
        exp_t e;
        int   t0, p0;
        bit   en_ok = 1;
        @(posedge clk); #1;
        bus.if_req = 1; bus.if_addr = 32'h44;
        t0 = cyc;
        p0 = if_pulses;
        for (int rel = 0; rel <= 12; rel++) begin
            @(negedge clk);
            if (bus.sram_en !== ((rel >= 1 && rel <= 4) || (rel >= 7 && rel <= 10))) en_ok = 0;
            if (rel == 5) begin
                total++;
                if (bus.if_ready !== 1'b0 || bus.if_rdata !== rd_pattern(32'h80)) begin
                    bad++;
                    $display("FAIL flush_no_update got=rdy%b %h want=rdy0 %h",
                             bus.if_ready, bus.if_rdata, rd_pattern(32'h80));
                end
            end
            if (bus.if_ready === 1'b1) begin
                total++;
                if (if_q.size() == 0) begin
                    bad++; $display("FAIL flush_extra got=ready@%0d want=none", rel);
                end else begin
                    e = if_q.pop_front();
                    if (bus.if_rdata !== e.data || cyc != e.cycle) begin
                        bad++;
                        $display("FAIL flush_next_data got=%h@%0d want=%h@%0d", bus.if_rdata, cyc, e.data, e.cycle);
                    end
                end
            end
            if (rel == 2) bus.if_req = 0;
            // A fresh fetch in cycle 6 is granted only if the FSM is back in IDLE.
            if (rel == 6) begin
                bus.if_req = 1; bus.if_addr = 32'h48;
                if_q.push_back('{rd_pattern(32'h48), t0 + 11});
            end
            if (rel == 11) bus.if_req = 0;
        end
        #1;
        total++;
        if (!en_ok) begin bad++; $display("FAIL flush_en got=bad_window want=cycles1-4,7-10"); end
        total++;
        if (if_pulses - p0 != 1) begin
            bad++; $display("FAIL flush_pulses got=%0d want=1", if_pulses - p0);
        end
        total++;
        if (if_q.size() != 0) begin
            bad++; $display("FAIL flush_missing got=no_ready want=ready@%0d", t0 + 11); if_q.delete();
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   t0, p0;
        bit   en_ok = 1;
        @(posedge clk); #1;
        bus.mem_read = 1; bus.mem_addr = 32'h300;
        t0 = cyc;
        p0 = mem_pulses;
        for (int rel = 0; rel <= 10; rel++) begin
            @(negedge clk);
            if (bus.sram_en !== ((rel >= 1 && rel <= 3) || (rel >= 5 && rel <= 8))) en_ok = 0;
            if (bus.mem_ready === 1'b1) begin
                total++;
                if (mem_q.size() == 0) begin
                    bad++; $display("FAIL rstmid_extra got=ready@%0d want=none", rel);
                end else begin
                    e = mem_q.pop_front();
                    if (bus.mem_rdata !== e.data || cyc != e.cycle) begin
                        bad++;
                        $display("FAIL rstmid_data got=%h@%0d want=%h@%0d", bus.mem_rdata, cyc, e.data, e.cycle);
                    end
                end
            end
            if (rel == 3) begin
                rst = 0;
                #1;
                total++;
                if (bus.sram_en !== 1'b0 || bus.mem_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL rstmid_async got=en%b rdy%b want=en0 rdy0", bus.sram_en, bus.mem_ready);
                end
            end
            if (rel == 4) begin
                rst = 1;
                mem_q.push_back('{rd_pattern(32'h300), t0 + 9});
            end
            if (rel == 9) bus.mem_read = 0;
        end
        #1;
        total++;
        if (!en_ok) begin bad++; $display("FAIL rstmid_en got=bad_window want=cycles1-3,5-8"); end
        total++;
        if (mem_pulses - p0 != 1) begin
            bad++; $display("FAIL rstmid_pulses got=%0d want=1", mem_pulses - p0);
        end
        total++;
        if (mem_q.size() != 0) begin
            bad++; $display("FAIL rstmid_missing got=no_ready want=ready@%0d", t0 + 9); mem_q.delete();
        end
    endtask

    task automatic test_hold_through_ready();
        exp_t e;
        int   t0, p0, r0;
        @(posedge clk); #1;
        bus.mem_read = 1; bus.mem_addr = 32'h104;
        t0 = cyc;
        p0 = mem_pulses;
        r0 = en_rises;
        mem_q.push_back('{rd_pattern(32'h104), t0 + 5});
        for (int rel = 0; rel <= 12; rel++) begin
            @(negedge clk);
            if (bus.mem_ready === 1'b1) begin
                total++;
                if (mem_q.size() == 0) begin
                    bad++; $display("FAIL hold_extra got=ready@%0d want=none", rel);
                end else begin
                    e = mem_q.pop_front();
                    if (bus.mem_rdata !== e.data || cyc != e.cycle) begin
                        bad++;
                        $display("FAIL hold_data got=%h@%0d want=%h@%0d", bus.mem_rdata, cyc, e.data, e.cycle);
                    end
                end
            end
            // Still high in the cycle after the pulse, dropped before the next edge.
            if (rel == 6) bus.mem_read = 0;
        end
        #1;
        total++;
        if (en_rises - r0 != 1) begin
            bad++; $display("FAIL hold_accesses got=%0d want=1", en_rises - r0);
        end
        total++;
        if (mem_pulses - p0 != 1) begin
            bad++; $display("FAIL hold_pulses got=%0d want=1", mem_pulses - p0);
        end
        total++;
        if (mem_q.size() != 0) begin
            bad++; $display("FAIL hold_missing got=no_ready want=ready@%0d", t0 + 5); mem_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_if_read();
        test_priority();
        test_mem_write();
        test_if_flush();
        test_reset_mid();
        test_hold_through_ready();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares the single external SRAM port between the IF stage (instruction fetch) and the MEM stage (loads/stores issued from the EX pipeline register). Grants one access at a time with fixed MEM-over-IF priority, sequences the fixed-latency SRAM access, returns data with a one-cycle ready pulse, and raises the pipeline `freeze` while a MEM access is outstanding. It sits between the stage modules and the SRAM pins at the top level.

## Interface
Parameters:
- `ADDR_W`, 32: address width, equal to `LEN_ADDRESS`.
- `DATA_W`, 32: data width, equal to `LEN_REGISTER`.
- `WAIT_CYCLES`, 4: SRAM access time in cycles, ≥1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch request; held until `if_ready`.
- `if_addr`  in  ADDR_W  fetch address.
- `if_rdata`  out  DATA_W  fetched word; valid while `if_ready`.
- `if_ready`  out  1  one-cycle completion pulse for IF.
- `mem_read`, `mem_write`  in  1 each  MEM stage request; mutually exclusive; held until `mem_ready`.
- `mem_addr`  in  ADDR_W  data address.
- `mem_wdata`  in  DATA_W  store data.
- `mem_rdata`  out  DATA_W  load data; valid while `mem_ready`.
- `mem_ready`  out  1  one-cycle completion pulse for MEM.
- `freeze`  out  1  `(mem_read|mem_write) & ~mem_ready`, combinational.
- `sram_en`, `sram_we`  out  1 each  SRAM access strobe and write enable.
- `sram_addr`  out  ADDR_W  registered address.
- `sram_wdata`  out  DATA_W  registered write data.
- `sram_rdata`  in  DATA_W  SRAM read data.

## Operation
- FSM has three states: `IDLE`, `BUSY`, `DONE`.
- `IDLE`: on an edge with a MEM request present, grant MEM. Otherwise, if `if_req` is present, grant IF. Otherwise stay in `IDLE`. On a grant: latch owner, address, wdata and we; assert `sram_en`; load the counter with `WAIT_CYCLES-1`; go to `BUSY`.
- `BUSY`: hold `sram_*` stable and decrement the counter. When the counter is 0, capture `sram_rdata` into the owner's rdata register, drop `sram_en`/`sram_we`, and go to `DONE`.
- `DONE`: pulse the owner's ready for exactly one cycle, then return to `IDLE` unconditionally. No re-grant happens in `DONE`, so a request held through its ready pulse is never issued twice.
- Simultaneous IF and MEM requests: MEM always wins. IF waits and is re-arbitrated in the next `IDLE`.
- Request withdrawn during `BUSY` (IF flushed on a taken branch): the SRAM access completes, the ready pulse is suppressed, and rdata is not updated.
- Writes: `mem_rdata` is left unchanged and `mem_ready` still pulses.
- Counter width is `$clog2(WAIT_CYCLES)`, minimum 1 bit. There is no wrap, because the counter only loads and counts down to 0.
- `mem_read` and `mem_write` both high is illegal; the block treats it as a write.

## Timing
- Reset (`rst` low, async): state `IDLE`. `sram_en`, `sram_we`, `if_ready` and `mem_ready` go to 0 immediately. `sram_addr`, `sram_wdata`, `if_rdata` and `mem_rdata` go to 0.
- Reset mid-access: the access is abandoned and no ready pulse is produced.
- Latency: request first high in cycle 0, in `IDLE` → `sram_en` high in cycles 1..WAIT_CYCLES → ready high in cycle WAIT_CYCLES+1. With the default, ready is high in cycle 5.
- Throughput: one access per WAIT_CYCLES+2 cycles (6 by default).
- `freeze` follows the MEM inputs combinationally and drops in the same cycle `mem_ready` is high.
- All other outputs are registered.

## Structure
- Shared defines file (with the ISA widths) gets:
  - state encodings `ARB_IDLE`, `ARB_BUSY`, `ARB_DONE` (2 bits);
  - owner encoding `OWN_IF` / `OWN_MEM`;
  - `SRAM_WAIT_CYCLES` default.
- One sub-module, `sram_wait_counter`: loadable down-counter with async active-low reset and a `zero` flag.
- The FSM, grant logic and data registers live in `sram_arbiter`.

## Test plan
- Reset then lone IF read of 0x40 (SRAM returns 0xE3A00005) → `sram_en` in cycles 1-4, `if_ready`=1 with `if_rdata`=0xE3A00005 in cycle 5 only, `freeze`=0 throughout.
- IF and MEM read requested together in cycle 0 → MEM served first (`mem_ready` in cycle 5), IF granted in cycle 6, `if_ready` in cycle 11; `freeze`=1 in cycles 0-4.
- MEM write of 0xDEADBEEF to 0x100 → `sram_we`=1 with a stable address/data for 4 cycles, `mem_ready` in cycle 5, `mem_rdata` unchanged.
- `if_req` dropped in cycle 2 of an IF access → SRAM access still completes, no `if_ready`, back to `IDLE` by cycle 6.
- `rst` pulled low in cycle 3 of a MEM read → `sram_en`=0 immediately, no `mem_ready`; after release, a held request is re-granted from `IDLE`.
- MEM read held high through its ready pulse, then dropped → exactly one SRAM access issued.
